// File: rtl/bp_gateway_io_pkg.sv
// Shared constants and types for the host-side io responder.
package bp_gateway_io_pkg;

  localparam logic [63:0] putchar_addr_gp     = 64'h0000_0000_0010_1000;
  localparam logic [63:0] getchar_addr_gp     = 64'h0000_0000_0010_0000;
  localparam logic [63:0] finish_base_addr_gp = 64'h0000_0000_0010_2000;
  localparam logic [63:0] cycle_addr_gp       = 64'h0000_0000_0010_3000;

  typedef enum logic [0:0] {e_ready, e_resp} io_state_e;

  // Width-independent part of the response; addr and payload are held alongside it.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [63:0] data;
  } io_resp_s;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] mask;
    unique case (size)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-file FIFO with valid/ready push and valid/yumi pop; els_p must be a power of 2.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               blackparrot_clk,
  input  logic               blackparrot_reset,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);

  // Extra wrap bit separates full from empty when the indices match.
  logic [ptr_width_lp:0] rptr_q, wptr_q;
  logic [width_p-1:0]    mem_q [els_p];
  logic                  empty, full, push, pop;

  assign empty = (rptr_q == wptr_q);
  assign full  = (rptr_q[ptr_width_lp] != wptr_q[ptr_width_lp])
              && (rptr_q[ptr_width_lp-1:0] == wptr_q[ptr_width_lp-1:0]);

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];
  assign push    = v_i & ~full;
  assign pop     = yumi_i & ~empty;

  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge blackparrot_clk) begin
    if (push) mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_gateway_io_responder.sv
// Host-side responder for chip io commands: putchar, getchar, per-core finish, optional cycle
// counter (built when BP_GATEWAY_IO_CYCLE_CTR_EN is defined). One command outstanding at a time.
module bp_gateway_io_responder
  import bp_gateway_io_pkg::*;
#(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned payload_width_p = 16,
  parameter int unsigned num_core_p      = 4,
  parameter int unsigned getchar_els_p   = 4
) (
  input  logic                       blackparrot_clk,
  input  logic                       blackparrot_reset,

  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_ready_o,
  input  logic                       io_cmd_wr_i,
  input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
  input  logic [1:0]                 io_cmd_size_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  input  logic [63:0]                io_cmd_data_i,

  output logic                       io_resp_v_o,
  input  logic                       io_resp_yumi_i,
  output logic                       io_resp_wr_o,
  output logic [paddr_width_p-1:0]   io_resp_addr_o,
  output logic [1:0]                 io_resp_size_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic [63:0]                io_resp_data_o,

  input  logic                       getchar_v_i,
  input  logic [7:0]                 getchar_i,
  output logic                       getchar_ready_o,

  output logic                       putchar_v_o,
  output logic [7:0]                 putchar_o,
  output logic [num_core_p-1:0]      finish_o,
  output logic                       all_finish_o,
  output logic                       err_o
);

  io_state_e                  state_q;
  io_resp_s                   resp_q;
  logic [paddr_width_p-1:0]   addr_q;
  logic [payload_width_p-1:0] payload_q;
  logic                       putchar_v_q;
  logic [7:0]                 putchar_q;
  logic [num_core_p-1:0]      finish_q;
  logic                       err_q;

  logic                       accept;
  logic [63:0]                addr_ext;
  logic                       is_putchar, is_getchar, is_finish;
  logic [8:0]                 finish_idx;
  logic [num_core_p-1:0]      finish_hit;
  logic [num_core_p-1:0]      finish_set;
  logic [63:0]                rdata, rdata_masked;
  logic                       cmd_err;

  logic                       fifo_v, fifo_yumi;
  logic [7:0]                 fifo_data;
  logic                       unused_bits;

  assign accept = io_cmd_v_i & (state_q == e_ready);

  bsg_fifo_1r1w_small #(
    .width_p (8),
    .els_p   (getchar_els_p)
  ) getchar_fifo (
    .blackparrot_clk   (blackparrot_clk),
    .blackparrot_reset (blackparrot_reset),
    .v_i               (getchar_v_i),
    .data_i            (getchar_i),
    .ready_o           (getchar_ready_o),
    .v_o               (fifo_v),
    .data_o            (fifo_data),
    .yumi_i            (fifo_yumi)
  );

  // An empty FIFO is never popped; that read answers all-ones instead.
  assign fifo_yumi = accept & is_getchar & ~io_cmd_wr_i & fifo_v;

`ifdef BP_GATEWAY_IO_CYCLE_CTR_EN
  logic [63:0] cycle_q;
  logic        is_cycle;

  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) cycle_q <= '0;
    else                    cycle_q <= cycle_q + 64'd1;
  end

  assign is_cycle = (addr_ext[63:3] == cycle_addr_gp[63:3]);
`endif

  // Addresses compare on the full width with the byte offset within the doubleword ignored.
  assign addr_ext   = 64'(io_cmd_addr_i);
  assign is_putchar = (addr_ext[63:3] == putchar_addr_gp[63:3]);
  assign is_getchar = (addr_ext[63:3] == getchar_addr_gp[63:3]);
  assign is_finish  = (addr_ext[63:12] == finish_base_addr_gp[63:12]);
  assign finish_idx = addr_ext[11:3];

  always_comb begin
    finish_hit = '0;
    for (int unsigned i = 0; i < num_core_p; i++) begin
      if (finish_idx == 9'(i)) finish_hit[i] = 1'b1;
    end
  end

  always_comb begin
    rdata      = '0;
    cmd_err    = 1'b0;
    finish_set = '0;
    if (is_putchar) begin
      rdata = '0;
    end else if (is_getchar) begin
      if (io_cmd_wr_i) cmd_err = 1'b1;
      else             rdata   = fifo_v ? 64'(fifo_data) : 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (is_finish) begin
      if (~|finish_hit)     cmd_err    = 1'b1;
      else if (io_cmd_wr_i) finish_set = finish_hit;
      else                  rdata      = 64'(|(finish_q & finish_hit));
    end
`ifdef BP_GATEWAY_IO_CYCLE_CTR_EN
    else if (is_cycle) begin
      if (io_cmd_wr_i) cmd_err = 1'b1;
      else             rdata   = cycle_q;
    end
`endif
    else begin
      cmd_err = 1'b1;
    end
    rdata_masked = io_cmd_wr_i ? 64'd0 : (rdata & size_mask(io_cmd_size_i));
  end

  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      state_q     <= e_ready;
      resp_q      <= '0;
      addr_q      <= '0;
      payload_q   <= '0;
      putchar_v_q <= 1'b0;
      putchar_q   <= '0;
      finish_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      putchar_v_q <= 1'b0;
      case (state_q)
        e_ready: begin
          if (io_cmd_v_i) begin
            state_q     <= e_resp;
            resp_q.wr   <= io_cmd_wr_i;
            resp_q.size <= io_cmd_size_i;
            resp_q.data <= rdata_masked;
            addr_q      <= io_cmd_addr_i;
            payload_q   <= io_cmd_payload_i;
            finish_q    <= finish_q | finish_set;
            if (cmd_err) err_q <= 1'b1;
            if (is_putchar & io_cmd_wr_i) begin
              putchar_v_q <= 1'b1;
              putchar_q   <= io_cmd_data_i[7:0];
            end
          end
        end
        e_resp: begin
          if (io_resp_yumi_i) state_q <= e_ready;
        end
        default: state_q <= e_ready;
      endcase
    end
  end

  assign io_cmd_ready_o    = (state_q == e_ready);
  assign io_resp_v_o       = (state_q == e_resp);
  assign io_resp_wr_o      = resp_q.wr;
  assign io_resp_addr_o    = addr_q;
  assign io_resp_size_o    = resp_q.size;
  assign io_resp_payload_o = payload_q;
  assign io_resp_data_o    = resp_q.data;
  assign putchar_v_o       = putchar_v_q;
  assign putchar_o         = putchar_q;
  assign finish_o          = finish_q;
  assign all_finish_o      = &finish_q;
  assign err_o             = err_q;

  assign unused_bits = ^{io_cmd_data_i[63:8], addr_ext[2:0]};

`ifndef SYNTHESIS
  yumi_without_v: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
    io_resp_yumi_i |-> io_resp_v_o);
`endif

endmodule
